// File: rtl/project4_calculator.sv
// 4-bit signed calculator driving 7-segment displays; every HEX output is registered.
// Optional sticky overflow indicator on HEX0 when STICKY_OVF_EN is defined.
module project4_calculator (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [2:0] KEY,
  input  logic [7:0] SW,
  output logic [6:0] HEX7,
  output logic [6:0] HEX6,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX0
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;

  // Segment pattern for a magnitude 0..8, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_digit(input logic [3:0] m);
    case (m)
      4'd0:    seg_digit = 7'h40;
      4'd1:    seg_digit = 7'h79;
      4'd2:    seg_digit = 7'h24;
      4'd3:    seg_digit = 7'h30;
      4'd4:    seg_digit = 7'h19;
      4'd5:    seg_digit = 7'h12;
      4'd6:    seg_digit = 7'h02;
      4'd7:    seg_digit = 7'h78;
      4'd8:    seg_digit = 7'h00;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

  // |v| as an unsigned magnitude; -8 yields 4'b1000 = 8.
  function automatic logic [3:0] mag4(input logic [3:0] v);
    mag4 = v[3] ? (~v + 4'd1) : v;
  endfunction

  function automatic logic [6:0] seg_sign(input logic [3:0] v);
    seg_sign = v[3] ? SEG_MINUS : SEG_BLANK;
  endfunction

  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] res;
  logic       ovf;
  logic       res_valid;
  logic [6:0] res_sign_seg;
  logic [6:0] res_mag_seg;
  logic       sticky;
  logic       show_e;

  assign op_a = SW[7:4];
  assign op_b = SW[3:0];

  always_comb begin
    res       = 4'd0;
    ovf       = 1'b0;
    res_valid = 1'b1;
    case (KEY)
      3'b000: begin
        res = op_a + op_b;
        ovf = (op_a[3] == op_b[3]) && (res[3] != op_a[3]);
      end
      3'b001: begin
        res = op_b + op_a;
        ovf = (op_a[3] == op_b[3]) && (res[3] != op_b[3]);
      end
      3'b010: begin
        res = op_a - op_b;
        ovf = (op_a[3] != op_b[3]) && (res[3] != op_a[3]);
      end
      3'b011: begin
        res = op_b - op_a;
        ovf = (op_b[3] != op_a[3]) && (res[3] != op_b[3]);
      end
      3'b100: begin
        res = mag4(op_a);
        ovf = (op_a == 4'b1000);
      end
      3'b101: begin
        res = mag4(op_b);
        ovf = (op_b == 4'b1000);
      end
      default: res_valid = 1'b0;
    endcase
  end

  // The wrapped result is never displayed: overflow and reserved ops blank the pair.
  always_comb begin
    res_sign_seg = SEG_BLANK;
    res_mag_seg  = SEG_BLANK;
    if (res_valid && !ovf) begin
      res_sign_seg = seg_sign(res);
      res_mag_seg  = seg_digit(mag4(res));
    end
  end

`ifdef STICKY_OVF_EN
  always_ff @(posedge CLOCK_50) begin
    if (RESET)
      sticky <= 1'b0;
    else if (ovf)
      sticky <= 1'b1;
  end
`else
  assign sticky = 1'b0;
`endif

  assign show_e = ovf || sticky;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      HEX7 <= SEG_BLANK;
      HEX6 <= SEG_BLANK;
      HEX5 <= SEG_BLANK;
      HEX4 <= SEG_BLANK;
      HEX3 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX0 <= SEG_BLANK;
    end else begin
      HEX7 <= seg_sign(op_a);
      HEX6 <= seg_digit(mag4(op_a));
      HEX5 <= seg_sign(op_b);
      HEX4 <= seg_digit(mag4(op_b));
      HEX3 <= res_sign_seg;
      HEX2 <= res_mag_seg;
      HEX0 <= show_e ? SEG_E : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_project4_calculator.sv
// Self-checking bench for project4_calculator: directed cases plus random stimulus
// compared against an integer-arithmetic reference model.
module tb_project4_calculator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key = 3'b000;
  logic [7:0] sw  = 8'h00;
  logic [6:0] hex7, hex6, hex5, hex4, hex3, hex2, hex0;

  int total = 0;
  int bad   = 0;
  logic        stk = 1'b0;
  logic [48:0] prev_exp = {7{7'h7F}};

  localparam logic [48:0] ALL_BLANK = {7{7'h7F}};

  project4_calculator dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .KEY     (key),
    .SW      (sw),
    .HEX7    (hex7),
    .HEX6    (hex6),
    .HEX5    (hex5),
    .HEX4    (hex4),
    .HEX3    (hex3),
    .HEX2    (hex2),
    .HEX0    (hex0)
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] outs();
    return {hex7, hex6, hex5, hex4, hex3, hex2, hex0};
  endfunction

  task automatic chk(input string tag, input logic [48:0] got, input logic [48:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] mag_seg(input int m);
    logic [6:0] tbl [9];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    return tbl[m];
  endfunction

  function automatic logic [6:0] sign_seg(input int v);
    return (v < 0) ? 7'h3F : 7'h7F;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: true integer result; overflow means it does not fit in -8..7.
  function automatic logic [48:0] model(input logic [2:0] k, input logic [7:0] s,
                                        input logic sticky_in, output logic ovf);
    logic [3:0] sa, sb;
    int a, b, r;
    bit valid;
    logic [6:0] rs, rm;
    sa = s[7:4];
    sb = s[3:0];
    a = $signed(sa);
    b = $signed(sb);
    valid = 1;
    r = 0;
    case (k)
      3'd0: r = a + b;
      3'd1: r = b + a;
      3'd2: r = a - b;
      3'd3: r = b - a;
      3'd4: r = iabs(a);
      3'd5: r = iabs(b);
      default: valid = 0;
    endcase
    ovf = valid && (r > 7 || r < -8);
    if (valid && !ovf) begin
      rs = sign_seg(r);
      rm = mag_seg(iabs(r));
    end else begin
      rs = 7'h7F;
      rm = 7'h7F;
    end
    return {sign_seg(a), mag_seg(iabs(a)), sign_seg(b), mag_seg(iabs(b)), rs, rm,
            (ovf || sticky_in) ? 7'h06 : 7'h7F};
  endfunction

  // Drive one input set; outputs must hold until the next edge, then show the new result.
  task automatic apply(input string tag, input logic [2:0] k, input logic [7:0] s);
    logic [48:0] exp;
    logic ovf;
    logic stk_use;
    rst = 1'b0;
    key = k;
    sw  = s;
`ifdef STICKY_OVF_EN
    stk_use = stk;
`else
    stk_use = 1'b0;
`endif
    exp = model(k, s, stk_use, ovf);
    #1;
    chk({tag, "_hold"}, outs(), prev_exp);
    @(posedge clk);
    #1;
    chk(tag, outs(), exp);
    if (ovf) stk = 1'b1;
    prev_exp = exp;
  endtask

  task automatic do_reset(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst = 1'b1;
      key = 3'($urandom);
      sw  = 8'($urandom);
      @(posedge clk);
      #1;
      chk(tag, outs(), ALL_BLANK);
    end
    stk = 1'b0;
    prev_exp = ALL_BLANK;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset("reset", 2);

    apply("add_1p3",    3'b000, 8'b0001_0011);
    apply("add_7p1",    3'b000, 8'b0111_0001);
    apply("add_m8pm2",  3'b000, 8'b1000_1110);
    apply("add_7p7",    3'b000, 8'b0111_0111);
    apply("add_m3pm2",  3'b000, 8'b1101_1110);
    apply("add_m8pm8",  3'b000, 8'b1000_1000);
    apply("sub_7m1",    3'b010, 8'b0111_0001);
    apply("sub_1m7",    3'b011, 8'b0111_0001);
    apply("sub_7mm7",   3'b010, 8'b0111_1001);
    apply("sub_m7mm7",  3'b011, 8'b1001_1001);
    apply("abs_m7",     3'b100, 8'b1001_0101);
    apply("abs_m8",     3'b100, 8'b1000_0011);
    apply("abs_b0",     3'b101, 8'b0110_0000);
    apply("rsvd_110",   3'b110, 8'b0111_0001);
    apply("rsvd_111",   3'b111, 8'b1000_1000);
    apply("badd_7p1",   3'b001, 8'b0001_0111);

    // Overflow followed by a clean op: HEX0 stays 'E' only in the sticky build.
    do_reset("reset_mid", 1);
    apply("sticky_ovf", 3'b000, 8'b0111_0001);
    apply("sticky_ok",  3'b000, 8'b0001_0011);
    do_reset("reset_clr", 1);
    apply("after_rst",  3'b000, 8'b0001_0011);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0)
        do_reset("rnd_reset", 1);
      else
        apply("rnd", 3'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
